// File: rtl/vehicle_count_rx_if.sv
// Bundle carrying the UART line into the count receiver and the
// lane counts / status back out to the traffic controller side.
interface vehicle_count_rx_if;
    logic       rx;
    logic [3:0] count1;
    logic [3:0] count2;
    logic       count_valid;
    logic       frame_err;

    // Receiver side: consumes the line, drives the counts.
    modport master (
        input  rx,
        output count1,
        output count2,
        output count_valid,
        output frame_err
    );

    // PC/controller side: drives the line, consumes the counts.
    modport slave (
        output rx,
        input  count1,
        input  count2,
        input  count_valid,
        input  frame_err
    );
endinterface

// File: rtl/vehicle_count_rx.sv
// UART receiver + 4-byte frame parser that turns PC vehicle counts
// into stable lane counts, with a staleness watchdog.
module vehicle_count_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STALE_CYCLES = 50_000_000
) (
    input  logic                clk_50MHz,
    input  logic                reset,
    vehicle_count_rx_if.master  bus
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int WW   = $clog2(STALE_CYCLES + 1);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        P_HUNT,
        P_GOT_SYNC,
        P_GOT_C1,
        P_GOT_C2
    } p_state_t;

    // ---------------- synchronizer ----------------
    logic sync_q;
    logic rx_s;

    // Two flops bring the asynchronous line into the clock domain.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            sync_q <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_q <= bus.rx;
            rx_s   <= sync_q;
        end
    end

    // ---------------- receiver ----------------
    rx_state_t      rx_state;
    rx_state_t      rx_next;
    logic [CW-1:0]  clk_cnt;
    logic [CW-1:0]  clk_cnt_n;
    logic [2:0]     bit_idx;
    logic [2:0]     bit_idx_n;
    logic [7:0]     shift;
    logic [7:0]     shift_n;
    logic           byte_stb;
    logic           byte_stb_n;
    logic           rx_ferr;

    // Receiver state, bit timer, bit index, shift register, byte strobe.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            byte_stb <= 1'b0;
        end else begin
            rx_state <= rx_next;
            clk_cnt  <= clk_cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            byte_stb <= byte_stb_n;
        end
    end

    // Receiver next state: half-bit start check, mid-bit data/stop samples.
    always_comb begin
        rx_next    = rx_state;
        clk_cnt_n  = clk_cnt + CW'(1);
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        byte_stb_n = 1'b0;
        rx_ferr    = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                clk_cnt_n = '0;
                if (!rx_s) begin
                    rx_next = RX_START;
                end
            end
            RX_START: begin
                if (clk_cnt == CW'(HALF - 1)) begin
                    clk_cnt_n = '0;
                    bit_idx_n = '0;
                    if (rx_s) begin
                        rx_next = RX_IDLE;
                    end else begin
                        rx_next = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_n = '0;
                    shift_n   = {rx_s, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        rx_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_n = '0;
                    rx_next   = RX_IDLE;
                    if (rx_s) begin
                        byte_stb_n = 1'b1;
                    end else begin
                        rx_ferr = 1'b1;
                    end
                end
            end
            default: begin
                rx_next = RX_IDLE;
            end
        endcase
    end

    // ---------------- parser ----------------
    p_state_t    p_state;
    p_state_t    p_next;
    logic [3:0]  sh1;
    logic [3:0]  sh1_n;
    logic [3:0]  sh2;
    logic [3:0]  sh2_n;
    logic        commit;
    logic        perr;
    logic        bad;
    logic [7:0]  chk;

    assign chk = SYNC_BYTE ^ {4'h0, sh1} ^ {4'h0, sh2};

    // Parser state and the shadow counts of the frame in progress.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            p_state <= P_HUNT;
            sh1     <= '0;
            sh2     <= '0;
        end else begin
            p_state <= p_next;
            sh1     <= sh1_n;
            sh2     <= sh2_n;
        end
    end

    // Parser next state: frame walk, checksum, resync on a stray sync byte.
    always_comb begin
        p_next = p_state;
        sh1_n  = sh1;
        sh2_n  = sh2;
        commit = 1'b0;
        perr   = 1'b0;
        bad    = 1'b0;
        if (rx_ferr) begin
            p_next = P_HUNT;
        end else if (byte_stb) begin
            unique case (p_state)
                P_HUNT: begin
                    if (shift == SYNC_BYTE) begin
                        p_next = P_GOT_SYNC;
                    end
                end
                P_GOT_SYNC: begin
                    if (shift[7:4] == 4'h0) begin
                        sh1_n  = shift[3:0];
                        p_next = P_GOT_C1;
                    end else begin
                        bad = 1'b1;
                    end
                end
                P_GOT_C1: begin
                    if (shift[7:4] == 4'h0) begin
                        sh2_n  = shift[3:0];
                        p_next = P_GOT_C2;
                    end else begin
                        bad = 1'b1;
                    end
                end
                P_GOT_C2: begin
                    if (shift == chk) begin
                        commit = 1'b1;
                        p_next = P_HUNT;
                    end else begin
                        bad = 1'b1;
                    end
                end
                default: begin
                    p_next = P_HUNT;
                end
            endcase
            if (bad) begin
                perr = 1'b1;
                if (shift == SYNC_BYTE) begin
                    p_next = P_GOT_SYNC;
                end else begin
                    p_next = P_HUNT;
                end
            end
        end
    end

    // ---------------- outputs and watchdog ----------------
    logic [3:0]    c1_q;
    logic [3:0]    c2_q;
    logic          valid_q;
    logic          ferr_q;
    logic [WW-1:0] wd;

    // Atomic commit of both counts; watchdog zeroes them when stale.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            c1_q    <= '0;
            c2_q    <= '0;
            valid_q <= 1'b0;
            wd      <= '0;
        end else if (commit) begin
            c1_q    <= sh1;
            c2_q    <= sh2;
            valid_q <= 1'b1;
            wd      <= '0;
        end else if (valid_q) begin
            if (wd == WW'(STALE_CYCLES - 1)) begin
                c1_q    <= '0;
                c2_q    <= '0;
                valid_q <= 1'b0;
                wd      <= WW'(STALE_CYCLES);
            end else begin
                wd <= wd + WW'(1);
            end
        end
    end

    // One-cycle error pulse for framing or parser rejects.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            ferr_q <= 1'b0;
        end else begin
            ferr_q <= rx_ferr | perr;
        end
    end

    assign bus.count1      = c1_q;
    assign bus.count2      = c2_q;
    assign bus.count_valid = valid_q;
    assign bus.frame_err   = ferr_q;

endmodule

// File: tb/tb_vehicle_count_rx.sv
// Bench for vehicle_count_rx: directed frames plus randomized
// frame streams checked against a byte-level reference model.
`timescale 1ns/1ps
module tb_vehicle_count_rx;

    localparam int CPB   = 8;
    localparam int STALE = 2000;

    logic clk_50MHz = 1'b0;
    logic reset     = 1'b0;

    vehicle_count_rx_if bus();

    vehicle_count_rx #(
        .CLKS_PER_BIT (CPB),
        .STALE_CYCLES (STALE)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .bus       (bus)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    always @(posedge clk_50MHz) cyc <= cyc + 1;

    // Event monitor sampled on the falling edge.
    logic [3:0] p1 = '0;
    logic [3:0] p2 = '0;
    logic       pfe = 1'b0;
    logic       pv  = 1'b0;
    int c1_chg  = 0;
    int c2_chg  = 0;
    int err_cnt = 0;
    int long_fe = 0;
    int drops   = 0;
    int last_start = 0;

    always @(negedge clk_50MHz) begin
        if (bus.count1 !== p1) c1_chg <= cyc;
        if (bus.count2 !== p2) c2_chg <= cyc;
        if (bus.frame_err === 1'b1) err_cnt <= err_cnt + 1;
        if (bus.frame_err === 1'b1 && pfe) long_fe <= long_fe + 1;
        if (pv && bus.count_valid !== 1'b1) drops <= drops + 1;
        p1  <= bus.count1;
        p2  <= bus.count2;
        pfe <= bus.frame_err;
        pv  <= bus.count_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    // Reference model state (spec-level frame rules).
    int         mst;
    logic [7:0] ms1;
    logic [7:0] ms2;
    logic [3:0] mc1;
    logic [3:0] mc2;
    logic       mvalid;
    int         merr;

    task automatic model_byte(input logic [7:0] b);
        logic is_bad;
        is_bad = 1'b0;
        if (mst == 0) begin
            if (b == 8'hA5) mst = 1;
        end else if (mst == 1 || mst == 2) begin
            if (b[7:4] != 4'h0) begin
                is_bad = 1'b1;
            end else begin
                if (mst == 1) ms1 = b;
                else ms2 = b;
                mst = mst + 1;
            end
        end else begin
            if (b == (8'hA5 ^ ms1 ^ ms2)) begin
                mc1    = ms1[3:0];
                mc2    = ms2[3:0];
                mvalid = 1'b1;
                mst    = 0;
            end else begin
                is_bad = 1'b1;
            end
        end
        if (is_bad) begin
            merr = merr + 1;
            mst  = (b == 8'hA5) ? 1 : 0;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_50MHz);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.rx     = 1'b0;
        last_start = cyc;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            step(CPB);
        end
        bus.rx = stop;
        step(CPB);
        bus.rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
    endtask

    task automatic test_reset;
        bus.rx = 1'b1;
        reset  = 1'b0;
        #5;
        checks++;
        if (bus.count1 !== 4'h0) begin
            errors++;
            $display("FAIL reset_count1 got %0h want 0", bus.count1);
        end
        checks++;
        if (bus.count2 !== 4'h0) begin
            errors++;
            $display("FAIL reset_count2 got %0h want 0", bus.count2);
        end
        checks++;
        if (bus.count_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %0b want 0", bus.count_valid);
        end
        checks++;
        if (bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ferr got %0b want 0", bus.frame_err);
        end
        step(3);
        reset = 1'b1;
        step(10);
    endtask

    task automatic test_valid_frame;
        int e0;
        int lat;
        e0 = err_cnt;
        send_frame(8'hA5, 8'h03, 8'h07, 8'hA1);
        step(10);
        lat = c1_chg - last_start;
        checks++;
        if (bus.count1 !== 4'h3 || bus.count2 !== 4'h7) begin
            errors++;
            $display("FAIL valid_counts got %0h/%0h want 3/7",
                     bus.count1, bus.count2);
        end
        checks++;
        if (bus.count_valid !== 1'b1) begin
            errors++;
            $display("FAIL valid_flag got %0b want 1", bus.count_valid);
        end
        checks++;
        if (err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL valid_noerr got %0d want 0", err_cnt - e0);
        end
        checks++;
        if (c1_chg !== c2_chg) begin
            errors++;
            $display("FAIL valid_atomic got %0d want %0d", c2_chg, c1_chg);
        end
        checks++;
        if (lat < 9 * CPB + CPB / 2 + 2 || lat > 10 * CPB + 4) begin
            errors++;
            $display("FAIL valid_latency got %0d want %0d..%0d",
                     lat, 9 * CPB + CPB / 2 + 2, 10 * CPB + 4);
        end
    endtask

    task automatic test_bad_checksum;
        int e0;
        e0 = err_cnt;
        send_frame(8'hA5, 8'h02, 8'h05, 8'h00);
        step(10);
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL badchk_err got %0d want 1", err_cnt - e0);
        end
        checks++;
        if (bus.count1 !== 4'h3 || bus.count2 !== 4'h7) begin
            errors++;
            $display("FAIL badchk_hold got %0h/%0h want 3/7",
                     bus.count1, bus.count2);
        end
        send_frame(8'hA5, 8'h02, 8'h05, 8'hA2);
        step(10);
        checks++;
        if (bus.count1 !== 4'h2 || bus.count2 !== 4'h5) begin
            errors++;
            $display("FAIL badchk_next got %0h/%0h want 2/5",
                     bus.count1, bus.count2);
        end
    endtask

    task automatic test_resync;
        int e0;
        logic [7:0] seq [6];
        e0 = err_cnt;
        seq = '{8'hA5, 8'h0F, 8'hA5, 8'h01, 8'h01, 8'hA5};
        for (int i = 0; i < 6; i++) send_byte(seq[i], 1'b1);
        step(10);
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL resync_err got %0d want 1", err_cnt - e0);
        end
        checks++;
        if (bus.count1 !== 4'h1 || bus.count2 !== 4'h1) begin
            errors++;
            $display("FAIL resync_counts got %0h/%0h want 1/1",
                     bus.count1, bus.count2);
        end
    endtask

    task automatic test_framing;
        int e0;
        e0 = err_cnt;
        send_byte(8'hA5, 1'b0);
        step(20);
        send_byte(8'h03, 1'b1);
        send_byte(8'h07, 1'b1);
        send_byte(8'hA1, 1'b1);
        step(10);
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL framing_err got %0d want 1", err_cnt - e0);
        end
        checks++;
        if (bus.count1 !== 4'h1 || bus.count2 !== 4'h1) begin
            errors++;
            $display("FAIL framing_hold got %0h/%0h want 1/1",
                     bus.count1, bus.count2);
        end
        checks++;
        if (bus.count_valid !== 1'b1) begin
            errors++;
            $display("FAIL framing_valid got %0b want 1", bus.count_valid);
        end
    endtask

    task automatic test_stale;
        int e1;
        int e2;
        int d;
        int k0;
        int dr0;
        send_frame(8'hA5, 8'h05, 8'h0A, 8'hAA);
        step(10);
        e1 = c1_chg;
        while (cyc < e1 + STALE - 3) step(1);
        checks++;
        if (bus.count_valid !== 1'b1 || bus.count1 !== 4'h5) begin
            errors++;
            $display("FAIL stale_before got %0b/%0h want 1/5",
                     bus.count_valid, bus.count1);
        end
        while (cyc < e1 + STALE + 2) step(1);
        checks++;
        if (bus.count_valid !== 1'b0 || bus.count1 !== 4'h0 ||
            bus.count2 !== 4'h0) begin
            errors++;
            $display("FAIL stale_after got %0b/%0h/%0h want 0/0/0",
                     bus.count_valid, bus.count1, bus.count2);
        end
        step(7);
        send_frame(8'hA5, 8'h06, 8'h0C, 8'hAF);
        step(10);
        e2 = c1_chg;
        d  = e2 - last_start;
        k0 = e2 + STALE - d - 3 * 10 * CPB;
        while (cyc < k0) step(1);
        dr0 = drops;
        send_frame(8'hA5, 8'h07, 8'h0B, 8'hA9);
        step(10);
        checks++;
        if (c1_chg !== e2 + STALE) begin
            errors++;
            $display("FAIL race_edge got %0d want %0d", c1_chg, e2 + STALE);
        end
        checks++;
        if (bus.count_valid !== 1'b1 || bus.count1 !== 4'h7 ||
            bus.count2 !== 4'hB) begin
            errors++;
            $display("FAIL race_commit got %0b/%0h/%0h want 1/7/b",
                     bus.count_valid, bus.count1, bus.count2);
        end
        checks++;
        if (drops - dr0 !== 0) begin
            errors++;
            $display("FAIL race_nodrop got %0d want 0", drops - dr0);
        end
    endtask

    task automatic test_reset_mid_frame;
        int e0;
        logic [7:0] c2b;
        c2b = 8'h07;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        bus.rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 3; i++) begin
            bus.rx = c2b[i];
            step(CPB);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.count1 !== 4'h0 || bus.count2 !== 4'h0 ||
            bus.count_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_out got %0h/%0h/%0b/%0b want 0/0/0/0",
                     bus.count1, bus.count2, bus.count_valid, bus.frame_err);
        end
        bus.rx = 1'b1;
        step(3);
        reset = 1'b1;
        step(20);
        e0 = err_cnt;
        send_frame(8'hA5, 8'h09, 8'h04, 8'hA8);
        step(10);
        checks++;
        if (bus.count1 !== 4'h9 || bus.count2 !== 4'h4 ||
            bus.count_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_frame got %0h/%0h/%0b want 9/4/1",
                     bus.count1, bus.count2, bus.count_valid);
        end
        checks++;
        if (err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL midreset_noerr got %0d want 0", err_cnt - e0);
        end
    endtask

    task automatic test_random_frames;
        int e_base;
        int gap;
        logic [7:0] f [4];
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        step(5);
        mst = 0; ms1 = '0; ms2 = '0;
        mc1 = '0; mc2 = '0; mvalid = 1'b0; merr = 0;
        e_base = err_cnt;
        for (int n = 0; n < 12; n++) begin
            f[0] = 8'hA5;
            f[1] = {4'h0, 4'($urandom_range(0, 15))};
            f[2] = {4'h0, 4'($urandom_range(0, 15))};
            f[3] = f[0] ^ f[1] ^ f[2];
            if (n % 3 != 0 && $urandom_range(0, 1) == 1) begin
                int j;
                j = $urandom_range(0, 3);
                f[j] = f[j] ^ (8'h01 << $urandom_range(0, 7));
            end
            for (int j = 0; j < 4; j++) begin
                send_byte(f[j], 1'b1);
                model_byte(f[j]);
                gap = $urandom_range(0, 15);
                if (gap > 0) step(gap);
            end
            step(12);
            checks++;
            if (bus.count1 !== mc1 || bus.count2 !== mc2) begin
                errors++;
                $display("FAIL rand_counts[%0d] got %0h/%0h want %0h/%0h",
                         n, bus.count1, bus.count2, mc1, mc2);
            end
            checks++;
            if (bus.count_valid !== mvalid) begin
                errors++;
                $display("FAIL rand_valid[%0d] got %0b want %0b",
                         n, bus.count_valid, mvalid);
            end
            checks++;
            if (err_cnt - e_base !== merr) begin
                errors++;
                $display("FAIL rand_errs[%0d] got %0d want %0d",
                         n, err_cnt - e_base, merr);
            end
        end
    endtask

    task automatic test_pulse_width;
        checks++;
        if (long_fe !== 0) begin
            errors++;
            $display("FAIL ferr_width got %0d want 0", long_fe);
        end
    endtask

    initial begin
        bus.rx = 1'b1;
        test_reset();
        test_valid_frame();
        test_bad_checksum();
        test_resync();
        test_framing();
        test_stale();
        test_reset_mid_frame();
        test_random_frames();
        test_pulse_width();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vehicle_count_rx.md
# vehicle_count_rx

Receives per-lane vehicle counts from the PC-side OpenCV counter over a UART line and presents them as stable 4-bit registers to the two-way traffic controller's `count1`/`count2` inputs. Contains a 2-FF input synchronizer, an 8N1 receiver and a 4-byte frame parser with checksum. It also has a staleness watchdog that zeroes the counts when the PC stops sending. It sits directly upstream of the traffic controller, in the same 50 MHz clock domain.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (115200 baud at 50 MHz); must be ≥ 4.
- `STALE_CYCLES`, 50_000_000, cycles without a valid frame before counts are invalidated (1 s).
- `clk_50MHz`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `rx`  in  1  UART line from PC, idle high, asynchronous to `clk_50MHz`.
- `count1`  out  4  lane-1 vehicle count, feeds controller `count1`.
- `count2`  out  4  lane-2 vehicle count, feeds controller `count2`.
- `count_valid`  out  1  high while counts come from a frame newer than `STALE_CYCLES`.
- `frame_err`  out  1  one-cycle pulse per rejected byte or frame.

## Operation
- Reset values: `count1`=0, `count2`=0, `count_valid`=0, `frame_err`=0. Receiver is IDLE, parser is HUNT, watchdog counter is 0, synchronizer flops are 1.
- **Synchronizer:** `rx` passes through 2 flops. All logic below uses the synchronized `rx_s`.
- **Receiver FSM (IDLE, START, DATA, STOP):**
  - IDLE → START on `rx_s` falling to 0.
  - START waits `CLKS_PER_BIT/2` cycles, then re-samples. If the sample is 0, go to DATA. If it is 1, the start was a glitch: return to IDLE with no error.
  - DATA samples 8 bits LSB-first, one every `CLKS_PER_BIT` cycles at mid-bit.
  - STOP samples once at mid-bit. If 1, issue an internal byte strobe. If 0, this is a framing error: pulse `frame_err`, discard the byte, and force the parser to HUNT.
  - After STOP, return to IDLE immediately; the remainder of the stop bit is not waited out.
- **Frame format:** `0xA5`, `C1`, `C2`, `CHK`.
  - `C1` and `C2` must have upper nibble 0.
  - `CHK` = `0xA5 ^ C1 ^ C2` (8-bit XOR).
- **Parser FSM (HUNT, GOT_SYNC, GOT_C1, GOT_C2):**
  - HUNT: `0xA5` → GOT_SYNC; any other byte is silently ignored.
  - GOT_SYNC: byte with upper nibble 0 → latch into shadow c1, go to GOT_C1. Otherwise → error.
  - GOT_C1: byte with upper nibble 0 → latch into shadow c2, go to GOT_C2. Otherwise → error.
  - GOT_C2: byte equal to the checksum → commit both shadows to `count1`/`count2` on the same edge, set `count_valid`=1, clear the watchdog, go to HUNT. Mismatch → error.
  - Error handling in any non-HUNT state: pulse `frame_err`. If the offending byte is `0xA5`, go to GOT_SYNC (resync); otherwise go to HUNT. Outputs keep their previous values.
- **Atomic update:** `count1` and `count2` always change on the same edge. A partial frame never alters either output.
- **Watchdog:**
  - Increments every cycle while `count_valid`=1 and saturates.
  - When it reaches `STALE_CYCLES`: `count1`=0, `count2`=0, `count_valid`=0, so the controller falls back to default timing.
  - Does not count while `count_valid`=0.
- **Simultaneous events:** a commit and a watchdog expiry on the same cycle resolve to the commit (new counts, `count_valid`=1, watchdog=0).
- **Reset mid-frame:** all state is discarded immediately. Any byte in flight is lost; the line is re-acquired at the next falling edge seen in IDLE.

## Timing
- Synchronizer latency: 2 cycles from `rx` to `rx_s`.
- The internal byte strobe is 1 cycle, issued on the cycle after the STOP mid-bit sample.
- Commit happens on the edge after the byte strobe. Net result: `count1`/`count2`/`count_valid` update 2 cycles after the `CHK` stop-bit sample.
- `frame_err` asserts for exactly 1 cycle:
  - on the cycle after the STOP sample for framing errors;
  - on the edge after the byte strobe for parser errors.
- Back-to-back bytes with zero idle time between the stop bit and the next start bit are supported. The minimum frame is 40 bit-times.

## Test plan
Benches use `CLKS_PER_BIT`=8 and `STALE_CYCLES`=2000.
- **Valid frame:** send `A5 03 07 A1` → `count1`=3, `count2`=7, `count_valid`=1, no `frame_err`. Both counts change on the same edge, 2 cycles after the stop sample.
- **Bad checksum:** send `A5 02 05 00` → one `frame_err` pulse, counts unchanged. Then `A5 02 05 A2` → `count1`=2, `count2`=5.
- **Resync:** send `A5 0F A5 01 01 A5` → `frame_err` once at the second `A5`. Then commit `count1`=1, `count2`=1.
- **Framing error:** send byte `A5` with stop bit 0, then `03 07 A1` → `frame_err` pulse, parser in HUNT, counts unchanged.
- **Stale:** after a valid frame, send nothing for 2000 cycles → `count1`=0, `count2`=0, `count_valid`=0. A new frame landing on the expiry cycle wins.
- **Reset mid-frame:** assert `reset`=0 during `C2` of a frame → all outputs 0 immediately. After release, a full frame `A5 09 04 A8` commits `count1`=9, `count2`=4.
